// File: rtl/soc_mem_pkg.sv
// Shared widths, byte-enable constant and fetch-master state encoding for the instruction memory path.
package soc_mem_pkg;

   localparam int         ADDR_W_DFLT = 15;
   localparam int         DATA_W_DFLT = 32;
   localparam logic [3:0] BYTEEN_ALL  = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      FINISH,
      ABORT
   } fetch_state_e;

endpackage

// File: rtl/imem_fetch_fifo.sv
// Prefetch FIFO: head word is read straight from storage registers, so a push is visible one cycle later.
// Never refuses a push that fits or arrives with a pop; flush empties it in one cycle and takes priority.
module imem_fetch_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        push_dat_i,
   input  logic                     pop_i,
   output logic                     out_vld_o,
   output logic [DATA_W-1:0]        out_dat_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [PW:0]       cnt_q;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != (PW+1)'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage is cleared on reset so the stream data output starts at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign out_vld_o = (cnt_q != '0);
   assign out_dat_o = mem_q[rd_ptr_q];
   assign count_o   = cnt_q;

endmodule

// File: rtl/imem_fetch_master.sv
// Avalon-MM read master streaming a word block from instruction memory into a valid/ready stream.
// First word READ_LATENCY+2 cycles after start; reads are credit-limited so the prefetch FIFO cannot overflow.
module imem_fetch_master
   import soc_mem_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DFLT,
   parameter int DATA_W       = DATA_W_DFLT,
   parameter int FIFO_DEPTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_chipselect,
   output logic [3:0]        m_byteenable,
   output logic              m_clken,
   input  logic              m_waitrequest,
   input  logic [DATA_W-1:0] m_readdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   localparam int FW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e            state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [15:0]             issued_q, issued_d;
   logic [15:0]             count_q, count_d;
   logic [READ_LATENCY-1:0] tag_q;

   logic [15:0]             tag_cnt;
   logic                    accept;
   logic                    push;
   logic                    credit_ok;
   logic                    fifo_vld;
   logic                    pop;
   logic [FW-1:0]           fifo_cnt;

   assign accept = m_read && !m_waitrequest;
   assign push   = tag_q[READ_LATENCY-1];
   assign pop    = out_valid && out_ready;

   // Every tag bit, including the one being pushed this cycle, is a word that
   // will land in the FIFO; that total plus current occupancy must leave room.
   always_comb begin
      tag_cnt = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         tag_cnt = tag_cnt + {15'd0, tag_q[i]};
      end
   end

   assign credit_ok = (16'(fifo_cnt) + tag_cnt) < 16'(FIFO_DEPTH);

   assign m_read       = (state_q == FETCH) && (issued_q < count_q) && credit_ok;
   assign m_chipselect = m_read;
   assign m_address    = addr_q;
   assign m_byteenable = BYTEEN_ALL;
   assign m_clken      = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= accept;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         issued_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         issued_q <= issued_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      issued_d = issued_q;
      count_d  = count_q;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               count_d  = word_count;
               issued_d = '0;
               state_d  = (word_count == 16'd0) ? FINISH : FETCH;
            end
         end
         FETCH: begin
            busy = 1'b1;
            if (accept) begin
               addr_d   = addr_q + ADDR_W'(1);
               issued_d = issued_q + 16'd1;
               if ((issued_q + 16'd1) == count_q) begin
                  state_d = DRAIN;
               end
            end
            if (abort) begin
               state_d = ABORT;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               state_d = ABORT;
            end else if ((tag_cnt == 16'd0) &&
                         ((fifo_cnt == '0) || ((fifo_cnt == FW'(1)) && pop))) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ABORT: begin
            busy = 1'b1;
            if (tag_cnt == 16'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Returns that arrive while aborting are dropped; the FIFO is held flushed.
   imem_fetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush_i    (state_q == ABORT),
      .push_i     (push && (state_q != ABORT)),
      .push_dat_i (m_readdata),
      .pop_i      (pop),
      .out_vld_o  (fifo_vld),
      .out_dat_o  (out_data),
      .count_o    (fifo_cnt)
   );

   assign out_valid = fifo_vld && (state_q != ABORT);

endmodule

// File: tb/tb_imem_fetch_master.sv
// Directed bench for imem_fetch_master with a one-cycle-latency memory model and a data/address scoreboard.
module tb_imem_fetch_master;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [14:0] base_addr;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic [14:0] m_address;
   logic        m_read;
   logic        m_chipselect;
   logic [3:0]  m_byteenable;
   logic        m_clken;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   imem_fetch_master dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .abort         (abort),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .busy          (busy),
      .done          (done),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_chipselect  (m_chipselect),
      .m_byteenable  (m_byteenable),
      .m_clken       (m_clken),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memval(input logic [14:0] a);
      return 32'(a) * 32'h11111111;
   endfunction

   // Memory preloaded with mem[i] = i * 0x11111111, one cycle read latency.
   always @(posedge clk) begin
      if (m_read && m_chipselect && !m_waitrequest) begin
         m_readdata <= memval(m_address);
      end
   end

   int          total;
   int          bad;
   int          cyc;
   int          acc_cnt;
   int          done_cnt;
   int          xfer_pops;
   int          last_pop_cyc;
   logic        wr_alt;
   logic        prev_stall;
   logic [14:0] prev_adr;
   logic        prev_out_hold;
   logic [31:0] prev_out_dat;
   logic [31:0] exp_dat[$];
   logic [14:0] exp_adr[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      logic [31:0] d;
      logic [14:0] a;
      if (done) begin
         done_cnt++;
         chk("done_busy_low", busy, 1'b0);
         if (xfer_pops > 0) chk("done_after_last", cyc, last_pop_cyc + 1);
      end
      if (prev_stall) begin
         chk("hold_read", m_read, 1'b1);
         chk("hold_addr", m_address, prev_adr);
      end
      if (prev_out_hold && out_valid) chk("out_stable", out_data, prev_out_dat);
      if (m_read && !m_waitrequest) begin
         acc_cnt++;
         chk("addr_expected", exp_adr.size() > 0, 1'b1);
         if (exp_adr.size() > 0) begin
            a = exp_adr.pop_front();
            chk("addr", m_address, a);
         end
      end
      if (out_valid && out_ready) begin
         xfer_pops++;
         last_pop_cyc = cyc;
         chk("word_expected", exp_dat.size() > 0, 1'b1);
         if (exp_dat.size() > 0) begin
            d = exp_dat.pop_front();
            chk("data", out_data, d);
         end
      end
      prev_stall    = m_read && m_waitrequest;
      prev_adr      = m_address;
      prev_out_hold = out_valid && !out_ready;
      prev_out_dat  = out_data;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      m_waitrequest = wr_alt ? ~m_waitrequest : 1'b0;
   endtask

   task automatic do_start(input logic [14:0] base, input logic [15:0] cnt);
      for (int i = 0; i < int'(cnt); i++) begin
         exp_adr.push_back(15'(base + 15'(i)));
         exp_dat.push_back(memval(15'(base + 15'(i))));
      end
      acc_cnt    = 0;
      xfer_pops  = 0;
      base_addr  = base;
      word_count = cnt;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      chk(tag, done_cnt, d0 + 1);
      chk("words_left", exp_dat.size(), 0);
      chk("addrs_left", exp_adr.size(), 0);
   endtask

   initial begin
      int d0;
      total = 0; bad = 0; cyc = 0; acc_cnt = 0; done_cnt = 0;
      xfer_pops = 0; last_pop_cyc = 0; wr_alt = 1'b0;
      prev_stall = 1'b0; prev_adr = '0; prev_out_hold = 1'b0; prev_out_dat = '0;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
      m_waitrequest = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_read", m_read, 1'b0);
      chk("rst_cs", m_chipselect, 1'b0);
      chk("rst_addr", m_address, 15'h0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 32'h0);
      chk("byteen", m_byteenable, 4'hF);
      chk("clken", m_clken, 1'b1);
      reset_n = 1'b1;
      tick();

      // Basic transfer: cycle-exact start-up and first-word latency.
      do_start(15'h0010, 16'd4);
      chk("c1_busy", busy, 1'b1);
      chk("c1_read", m_read, 1'b1);
      chk("c1_addr", m_address, 15'h0010);
      tick();
      chk("c2_valid", out_valid, 1'b0);
      tick();
      chk("c3_valid", out_valid, 1'b1);
      chk("c3_data", out_data, 32'h11111110);
      wait_done("basic_done", 50);
      chk("basic_reads", acc_cnt, 4);
      d0 = done_cnt;
      tick(); tick();
      chk("basic_single_done", done_cnt, d0);

      // Back-pressure: credit must stop reads at FIFO depth.
      do_start(15'h0200, 16'd20);
      out_ready = 1'b0;
      repeat (30) tick();
      chk("bp_reads", acc_cnt, 8);
      chk("bp_stall", m_read, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      wait_done("bp_done", 100);
      chk("bp_total_reads", acc_cnt, 20);

      // Alternating waitrequest.
      wr_alt = 1'b1;
      do_start(15'h0040, 16'd6);
      wait_done("wr_done", 80);
      wr_alt = 1'b0;
      tick();

      // Zero length.
      do_start(15'h0005, 16'd0);
      chk("zero_done", done, 1'b1);
      chk("zero_busy", busy, 1'b0);
      chk("zero_read", m_read, 1'b0);
      d0 = done_cnt;
      repeat (4) tick();
      chk("zero_one_pulse", done_cnt, d0 + 1);
      chk("zero_no_reads", acc_cnt, 0);

      // Address wrap.
      do_start(15'h7FFE, 16'd3);
      wait_done("wrap_done", 40);
      chk("wrap_reads", acc_cnt, 3);

      // Abort after the 5th accepted read of 16.
      do_start(15'h0300, 16'd16);
      for (int i = 0; i < 20 && acc_cnt < 5; i++) tick();
      chk("abort_reach5", acc_cnt, 5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_dat.delete();
      exp_adr.delete();
      d0 = done_cnt;
      chk("abort_read_low", m_read, 1'b0);
      chk("abort_valid_low", out_valid, 1'b0);
      chk("abort_busy", busy, 1'b1);
      for (int i = 0; i < 10 && busy; i++) tick();
      chk("abort_busy_fell", busy, 1'b0);
      chk("abort_valid_idle", out_valid, 1'b0);
      repeat (2) tick();
      chk("abort_no_done", done_cnt, d0);
      do_start(15'h0020, 16'd5);
      wait_done("post_abort_done", 50);

      // Asynchronous reset mid-fetch.
      do_start(15'h0100, 16'd10);
      tick(); tick();
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_read", m_read, 1'b0);
      chk("arst_cs", m_chipselect, 1'b0);
      chk("arst_addr", m_address, 15'h0);
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_data", out_data, 32'h0);
      exp_dat.delete();
      exp_adr.delete();
      prev_stall = 1'b0;
      prev_out_hold = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_valid", out_valid, 1'b0);
         chk("post_rst_busy", busy, 1'b0);
      end
      do_start(15'h0008, 16'd2);
      wait_done("post_rst_done", 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_fetch_master.md
# imem_fetch_master

Avalon-MM read master that streams a block of 32-bit words out of the on-chip instruction memory (s1, single-port altsyncram, fixed read latency) into a valid/ready output stream. It sits between a processor-side loader/debug agent and the instruction memory slave port. It issues pipelined reads under credit control, so that the internal prefetch FIFO never overflows.

## Interface
Parameters:
- ADDR_W, 15, word address width; matches the slave address port.
- DATA_W, 32, data width.
- FIFO_DEPTH, 8, prefetch FIFO entries; power of two, ≥ 2.
- READ_LATENCY, 1, cycles from an accepted read to valid m_readdata; fixed, ≥ 1.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  cancels the current transfer; ignored in IDLE.
- base_addr  in  ADDR_W  first word address, latched on start.
- word_count  in  16  number of words, latched on start; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done or abort completes.
- done  out  1  one-cycle pulse after the last word leaves the stream.
- m_address  out  ADDR_W  read address.
- m_read  out  1  read request.
- m_chipselect  out  1  equal to m_read.
- m_byteenable  out  4  constant 4'hF.
- m_clken  out  1  constant 1.
- m_waitrequest  in  1  interconnect stall; tie 0 for a direct connection.
- m_readdata  in  DATA_W  read data.
- out_valid  out  1  stream valid.
- out_data  out  DATA_W  stream data.
- out_ready  in  1  consumer ready.

## Operation
- States:
  - IDLE: start → FETCH, or → FINISH if word_count = 0.
  - FETCH: moves to DRAIN when the issued count reaches word_count.
  - DRAIN: → FINISH when in-flight = 0, the FIFO is empty and the last word has popped.
  - FINISH: one cycle, done = 1, then → IDLE.
  - ABORT: waits for in-flight = 0, flushes the FIFO, then → IDLE with no done pulse.
- Read acceptance: a read is accepted when m_read & !m_waitrequest.
  - On acceptance: the address increments by 1 and wraps modulo 2^ADDR_W. Keeping addresses below the memory depth (24576) is the caller's responsibility.
  - On acceptance: the issued count increments.
- Returns: a READ_LATENCY-deep valid shift register tags each accepted read. The tagged m_readdata is pushed into the FIFO READ_LATENCY edges after acceptance.
- Credit: m_read is asserted only if (FIFO occupancy + in-flight + push this cycle) < FIFO_DEPTH. The FIFO can never overflow, so no data is ever dropped.
- Holding a request: while m_waitrequest = 1, m_read and m_address hold stable.
- start while busy: ignored.
- abort while FETCH/DRAIN: m_read drops the next cycle. Returns still in flight are discarded. out_valid is forced low from the cycle after abort.
- start and abort in the same IDLE cycle: start wins and abort is ignored.
- Stream rule: a word transfers when out_valid & out_ready. out_data is stable while out_valid & !out_ready.

## Timing
- Reset values: busy=0, done=0, m_read=0, m_chipselect=0, m_address=0, out_valid=0, out_data=0. m_byteenable=4'hF and m_clken=1 always. State = IDLE, FIFO empty, all counters 0.
- Start-up (start seen at edge 0):
  - busy=1 and m_read=1 with m_address=base_addr during cycle 1.
  - With m_waitrequest=0, one read is issued per cycle.
- Output latency: first out_valid appears in cycle 2+READ_LATENCY, which is cycle 3 for the default.
- Throughput: sustains 1 word/cycle with out_ready held high and FIFO_DEPTH > READ_LATENCY+1.
- Completion: done pulses the cycle after the last stream transfer. busy falls in the same cycle as done.
- Zero-length transfer: done is high in cycle 1 and busy stays 0.
- Reset assertion mid-transfer: all state clears immediately (asynchronous). Any outstanding read results are ignored.

## Structure
- Package soc_mem_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum (IDLE, FETCH, DRAIN, FINISH, ABORT).
  - BYTEEN_ALL = 4'hF.
- Sub-module imem_fetch_fifo:
  - Synchronous FIFO, registered output.
  - Exposes an occupancy count for the credit logic.
  - Has a flush input.
- Top level holds the FSM, the address/issue/in-flight counters and the latency shift register.

## Test plan
- Basic transfer: base_addr=0x0010, word_count=4, memory preloaded with mem[i]=i*0x11111111, out_ready=1.
  - Required: out_data 0x11111111×16..19 pattern appears in order from cycle 3.
  - Required: done pulses once, 4 reads issued, addresses 0x10–0x13.
- Back-pressure: word_count=20, out_ready=0 for 30 cycles, then 1.
  - Required: exactly FIFO_DEPTH reads outstanding+buffered, then m_read stalls.
  - Required: all 20 words delivered with no loss or duplication.
- waitrequest: m_waitrequest high on alternate cycles.
  - Required: m_address and m_read held stable during each stall.
  - Required: the data sequence is unchanged.
- Zero count and wrap:
  - word_count=0 → done in cycle 1 with no m_read.
  - base_addr=0x7FFE, word_count=3 → addresses 0x7FFE, 0x7FFF, 0x0000.
- Abort: abort after the 5th accepted read of a 16-word transfer.
  - Required: m_read low the next cycle and out_valid low.
  - Required: no done; busy falls after the in-flight reads drain.
  - Required: a new start then transfers correctly.
- Reset: reset_n pulsed low mid-FETCH.
  - Required: all outputs reach their reset values asynchronously.
  - Required: there is no stale out_valid after release.
